// File: rtl/rf_spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// rf_spi_txn_ctrl
//
// Sequences one RF register transaction on top of a byte-level SPI engine:
// an opcode byte, then 0..MAX_LEN data bytes (written from the host byte
// stream or read back into rd_data). Chip select is held low across the whole
// transaction via spi_hold_csn. After each transaction, CSN stays high for a
// fixed guard gap.
//
// Optional feature (define RF_TXN_TIMEOUT_EN): an abort timer runs while the
// block waits for spi_done. Without the macro the block waits forever and
// txn_err is tied to 0.
//
// Parameters
//   MAX_LEN     max data bytes per transaction; a larger cmd_len is clamped
//   GAP_CYC     clk cycles spent in the inter-transaction gap (minimum 1)
//   TIMEOUT_CYC cycles from spi_start to abort (RF_TXN_TIMEOUT_EN only)
//
// Ports
//   clk, rstn                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        host command handshake
//   cmd_opcode/cmd_len/cmd_rd  command byte, data byte count, 1 = read
//   wr_data/wr_valid/wr_pop    host write byte stream; wr_pop = byte consumed
//   rd_data/rd_valid           read byte with 1-cycle valid pulse
//   status                     RX byte captured during the opcode byte
//   txn_done/txn_err           end-of-transaction pulse, abort flag
//   busy                       command accepted until end of gap
//   spi_start/spi_tx_byte/spi_hold_csn   requests to the byte engine
//   spi_rx_byte/spi_done/spi_busy        responses from the byte engine
// -----------------------------------------------------------------------------
module rf_spi_txn_ctrl #(
  parameter int MAX_LEN     = 32,
  parameter int GAP_CYC     = 20,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opcode,
  input  logic [5:0] cmd_len,
  input  logic       cmd_rd,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_pop,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] status,
  output logic       txn_done,
  output logic       txn_err,
  output logic       busy,
  output logic       spi_start,
  output logic [7:0] spi_tx_byte,
  output logic       spi_hold_csn,
  input  logic [7:0] spi_rx_byte,
  input  logic       spi_done,
  input  logic       spi_busy
);

  localparam logic [5:0] LEN_MAX    = 6'(MAX_LEN);
  // The gap counter runs 0..GAP_LAST; one cycle in GAP per count value.
  localparam int         GAP_LAST_I = (GAP_CYC > 1) ? GAP_CYC - 1 : 0;
  localparam int         GW         = $clog2(GAP_LAST_I + 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);

`ifdef RF_TXN_TIMEOUT_EN
  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt_reg;
`endif

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    OPC_WAIT,
    DAT,
    DAT_WAIT,
    GAP
  } state_t;

  state_t        state_reg;
  logic [7:0]    opcode_reg;
  logic [5:0]    len_reg;
  logic          rd_reg;
  logic [5:0]    cnt_reg;      // data bytes completed so far
  logic [GW-1:0] gap_cnt_reg;

  logic [5:0] len_clamped;
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      len_reg      <= '0;
      rd_reg       <= 1'b0;
      cnt_reg      <= '0;
      gap_cnt_reg  <= '0;
      cmd_ready    <= 1'b0;
      wr_pop       <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      status       <= '0;
      txn_done     <= 1'b0;
      txn_err      <= 1'b0;
      busy         <= 1'b0;
      spi_start    <= 1'b0;
      spi_tx_byte  <= '0;
      spi_hold_csn <= 1'b0;
`ifdef RF_TXN_TIMEOUT_EN
      tmo_cnt_reg  <= '0;
`endif
    end else begin
      // Single-cycle pulses default low every cycle.
      spi_start <= 1'b0;
      wr_pop    <= 1'b0;
      rd_valid  <= 1'b0;
      txn_done  <= 1'b0;
      txn_err   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opcode_reg   <= cmd_opcode;
            len_reg      <= len_clamped;
            rd_reg       <= cmd_rd;
            cnt_reg      <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            spi_hold_csn <= 1'b1;
            state_reg    <= OPC;
          end else begin
            // cmd_ready is registered, so it first rises one edge after reset.
            cmd_ready <= !spi_busy;
          end
        end

        OPC: begin
          if (!spi_busy) begin
            spi_start   <= 1'b1;
            spi_tx_byte <= opcode_reg;
            state_reg   <= OPC_WAIT;
`ifdef RF_TXN_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
        end

        OPC_WAIT: begin
          if (spi_done) begin
            status <= spi_rx_byte;
            if (len_reg == 6'd0) begin
              spi_hold_csn <= 1'b0;
              txn_done     <= 1'b1;
              gap_cnt_reg  <= '0;
              state_reg    <= GAP;
            end else begin
              state_reg <= DAT;
            end
          end
`ifdef RF_TXN_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            spi_hold_csn <= 1'b0;
            txn_done     <= 1'b1;
            txn_err      <= 1'b1;
            gap_cnt_reg  <= '0;
            state_reg    <= GAP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        DAT: begin
          // A write waits here with CSN held until the host offers a byte;
          // the abort timer is not running in this state.
          if (!spi_busy && (rd_reg || wr_valid)) begin
            spi_start   <= 1'b1;
            wr_pop      <= !rd_reg;
            spi_tx_byte <= rd_reg ? 8'hFF : wr_data;
            state_reg   <= DAT_WAIT;
`ifdef RF_TXN_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
        end

        DAT_WAIT: begin
          if (spi_done) begin
            if (rd_reg) begin
              rd_data  <= spi_rx_byte;
              rd_valid <= 1'b1;
            end
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg + 6'd1 == len_reg) begin
              spi_hold_csn <= 1'b0;
              txn_done     <= 1'b1;
              gap_cnt_reg  <= '0;
              state_reg    <= GAP;
            end else begin
              state_reg <= DAT;
            end
          end
`ifdef RF_TXN_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            spi_hold_csn <= 1'b0;
            txn_done     <= 1'b1;
            txn_err      <= 1'b1;
            gap_cnt_reg  <= '0;
            state_reg    <= GAP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        GAP: begin
          // Leave only after the full gap and once the engine has gone idle,
          // so the next transaction cannot start on a still-busy engine.
          if (gap_cnt_reg >= GAP_LAST && !spi_busy) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
          end else if (gap_cnt_reg < GAP_LAST) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_spi_txn_ctrl
//
// Bench for rf_spi_txn_ctrl. A behavioural byte engine and host write stream
// run on the falling clock edge; a transaction-level model predicts the byte
// sequence on the SPI side, the read data, status and pulse counts for each
// command. Directed vectors come from a table, followed by random commands
// and hand-written gap, reset and (with RF_TXN_TIMEOUT_EN) timeout sequences.
// -----------------------------------------------------------------------------
module tb_rf_spi_txn_ctrl;

  localparam int MAXL = 32;
  localparam int GAP  = 20;
  localparam int TMO  = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_opcode = 8'h00;
  logic [5:0] cmd_len = 6'd0;
  logic       cmd_rd = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_pop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] status;
  logic       txn_done;
  logic       txn_err;
  logic       busy;
  logic       spi_start;
  logic [7:0] spi_tx_byte;
  logic       spi_hold_csn;
  logic [7:0] spi_rx_byte = 8'h00;
  logic       spi_done = 1'b0;
  logic       spi_busy = 1'b0;

  rf_spi_txn_ctrl #(.MAX_LEN(MAXL), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_rd(cmd_rd),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .status(status),
    .txn_done(txn_done), .txn_err(txn_err), .busy(busy),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_hold_csn(spi_hold_csn),
    .spi_rx_byte(spi_rx_byte), .spi_done(spi_done), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Owned by the stimulus process.
  logic [7:0] wr_stream[$];
  logic [7:0] rx_stream[$];
  int  stall_idx = -1;
  int  stall_len = 0;
  int  eng_lat_max = 1;
  int  eng_tail_max = 0;
  bit  eng_withhold = 1'b0;

  // Owned by the engine/monitor process.
  logic [7:0] obs_tx[$];
  logic [7:0] obs_rd[$];
  int n_start = 0, n_pop = 0, n_rdv = 0, n_done = 0, n_err_done = 0, n_rx = 0;
  int csn_viol = 0, stab_viol = 0, stall_viol = 0;
  int eng_left = 0, eng_tail = 0, stall_cnt = 0;
  bit mid_txn = 1'b0, eng_active = 1'b0, prev_stall = 1'b0, stall_now;
  logic [7:0] eng_byte = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Byte engine, host write stream and output monitor.
  always @(negedge clk) begin
    if (!rstn) begin
      spi_busy   = 1'b0;
      spi_done   = 1'b0;
      eng_active = 1'b0;
      eng_tail   = 0;
      mid_txn    = 1'b0;
      wr_valid   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (mid_txn && !spi_hold_csn && !txn_done) csn_viol++;
      if (spi_start) begin
        obs_tx.push_back(spi_tx_byte);
        n_start++;
        if (!spi_hold_csn) csn_viol++;
        if (prev_stall) stall_viol++;
        mid_txn = 1'b1;
      end
      if (wr_pop) n_pop++;
      if (rd_valid) begin
        obs_rd.push_back(rd_data);
        n_rdv++;
      end
      if (txn_done) begin
        n_done++;
        if (txn_err) n_err_done++;
        mid_txn = 1'b0;
      end
      if (eng_active && spi_tx_byte !== eng_byte) stab_viol++;

      if (spi_done) begin
        spi_done = 1'b0;
        eng_tail = $urandom_range(0, eng_tail_max);
        if (eng_tail == 0) spi_busy = 1'b0;
      end else if (eng_tail > 0) begin
        eng_tail--;
        if (eng_tail == 0) spi_busy = 1'b0;
      end
      if (spi_start) begin
        spi_busy   = 1'b1;
        eng_active = 1'b1;
        eng_byte   = spi_tx_byte;
        eng_left   = $urandom_range(1, eng_lat_max);
      end else if (eng_active && !eng_withhold) begin
        if (eng_left > 1) eng_left--;
        else begin
          spi_done    = 1'b1;
          spi_rx_byte = (n_rx < rx_stream.size()) ? rx_stream[n_rx] : 8'hA5;
          n_rx++;
          eng_active  = 1'b0;
        end
      end

      stall_now = (n_pop == stall_idx) && (stall_cnt < stall_len);
      if (stall_now) stall_cnt++;
      wr_valid   = (n_pop < wr_stream.size()) && !stall_now;
      wr_data    = (n_pop < wr_stream.size()) ? wr_stream[n_pop] : 8'h00;
      prev_stall = stall_now;
    end
  end

  typedef struct {
    string      name;
    logic [7:0] op;
    int         len;
    bit         rd;
    logic [7:0] stat;
    logic [7:0] base;
    int         stall;
    int         exp_starts;
    int         exp_pops;
    int         exp_rdv;
  } vec_t;

  function automatic logic [31:0] all_outs();
    return {cmd_ready, wr_pop, rd_data, rd_valid, status, txn_done, txn_err,
            busy, spi_start, spi_tx_byte, spi_hold_csn};
  endfunction

  task automatic drop_unused();
    while (wr_stream.size() > n_pop) void'(wr_stream.pop_back());
    while (rx_stream.size() > n_rx) void'(rx_stream.pop_back());
  endtask

  task automatic issue_cmd(input logic [7:0] op, input int len, input bit rd);
    int k;
    cmd_opcode = op;
    cmd_len    = 6'(len);
    cmd_rd     = rd;
    cmd_valid  = 1'b1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!txn_done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check({nm, " done_seen"}, {31'd0, txn_done}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < GAP + 200) begin
      @(negedge clk);
      k++;
    end
    check({nm, " busy_release"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_txn(input vec_t v, input bit ramp, input int lat, input int tail);
    int n, bad, b_tx, b_rd, b_start, b_pop, b_rdv, b_done, b_err, b_csn, b_stab, b_stall;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] b;
    n = (v.len > MAXL) ? MAXL : v.len;
    drop_unused();
    eng_lat_max  = lat;
    eng_tail_max = tail;
    exp_tx.push_back(v.op);
    rx_stream.push_back(v.stat);
    for (int i = 0; i < n; i++) begin
      b = ramp ? 8'(v.base + 8'(i)) : 8'($urandom);
      if (v.rd) begin
        exp_tx.push_back(8'hFF);
        exp_rd.push_back(b);
        rx_stream.push_back(b);
      end else begin
        exp_tx.push_back(b);
        wr_stream.push_back(b);
        rx_stream.push_back(8'($urandom));
      end
    end
    if (v.stall > 0) begin
      stall_idx = n_pop + 1;
      stall_len = v.stall;
    end
    b_tx = obs_tx.size(); b_rd = obs_rd.size();
    b_start = n_start; b_pop = n_pop; b_rdv = n_rdv; b_done = n_done; b_err = n_err_done;
    b_csn = csn_viol; b_stab = stab_viol; b_stall = stall_viol;

    issue_cmd(v.op, v.len, v.rd);
    wait_done(v.name);
    repeat (2) @(negedge clk);

    check({v.name, " starts"}, n_start - b_start, v.exp_starts);
    check({v.name, " wr_pops"}, n_pop - b_pop, v.exp_pops);
    check({v.name, " rd_valids"}, n_rdv - b_rdv, v.exp_rdv);
    check({v.name, " txn_done_cnt"}, n_done - b_done, 1);
    check({v.name, " txn_err_cnt"}, n_err_done - b_err, 0);
    check({v.name, " status"}, {24'd0, status}, {24'd0, v.stat});
    bad = 0;
    for (int i = 0; i < exp_tx.size(); i++)
      if (b_tx + i >= obs_tx.size() || obs_tx[b_tx + i] !== exp_tx[i]) bad++;
    check({v.name, " tx_bytes_wrong"}, bad, 0);
    bad = 0;
    for (int i = 0; i < exp_rd.size(); i++)
      if (b_rd + i >= obs_rd.size() || obs_rd[b_rd + i] !== exp_rd[i]) bad++;
    check({v.name, " rd_bytes_wrong"}, bad, 0);
    check({v.name, " csn_violations"}, csn_viol - b_csn, 0);
    check({v.name, " tx_unstable"}, stab_viol - b_stab, 0);
    check({v.name, " start_in_stall"}, stall_viol - b_stall, 0);
    check({v.name, " hold_csn_after"}, {31'd0, spi_hold_csn}, 32'd0);
    wait_idle(v.name);
    $display("txn %-12s op=%02h len=%0d rd=%0b starts=%0d rd_bytes=%0d status=%02h",
             v.name, v.op, v.len, v.rd, n_start - b_start, n_rdv - b_rdv, status);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    int n, k, low_busy, b_rdv;

    tbl[0] = '{"opc_only",  8'hE1, 0,  1'b0, 8'h0E, 8'h00, 0,  1,  0,  0};
    tbl[1] = '{"wr1",       8'h20, 1,  1'b0, 8'h33, 8'h0B, 0,  2,  1,  0};
    tbl[2] = '{"rd32",      8'h61, 32, 1'b1, 8'h7C, 8'h00, 0,  33, 0,  32};
    tbl[3] = '{"wr3_stall", 8'h24, 3,  1'b0, 8'h41, 8'hC0, 50, 4,  3,  0};
    tbl[4] = '{"rd40_clamp",8'h62, 40, 1'b1, 8'h18, 8'h80, 0,  33, 0,  32};
    tbl[5] = '{"wr63_clamp",8'h2A, 63, 1'b0, 8'h99, 8'h10, 0,  33, 32, 0};

    // Reset state, and cmd_ready stays low until the first edge after release.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rstn = 1'b1;
    #1 check("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    check("busy_after_reset", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], 1'b1, 3, 1);

    for (int i = 0; i < 20; i++) begin
      rv.name  = $sformatf("rand%0d", i);
      rv.op    = 8'($urandom);
      rv.len   = $urandom_range(0, 40);
      rv.rd    = 1'($urandom);
      rv.stat  = 8'($urandom);
      rv.base  = 8'h00;
      rv.stall = 0;
      n = (rv.len > MAXL) ? MAXL : rv.len;
      rv.exp_starts = 1 + n;
      rv.exp_pops   = rv.rd ? 0 : n;
      rv.exp_rdv    = rv.rd ? n : 0;
      run_txn(rv, 1'b0, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    // Command held through the gap is taken exactly when the gap ends.
    drop_unused();
    rx_stream.push_back(8'h3C);
    rx_stream.push_back(8'h4D);
    issue_cmd(8'hE1, 0, 1'b0);
    wait_done("gap_a");
    cmd_opcode = 8'h05; cmd_len = 6'd0; cmd_rd = 1'b0; cmd_valid = 1'b1;
    k = 0; low_busy = 0;
    while (!cmd_ready && k < GAP + 20) begin
      @(negedge clk);
      k++;
      if (!busy && !cmd_ready) low_busy++;
    end
    check("gap_length", k, GAP);
    check("gap_busy_held", low_busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("gap_b");
    repeat (2) @(negedge clk);
    check("gap_b status", {24'd0, status}, 32'h4D);
    wait_idle("gap_b");
    $display("txn %-12s held cmd accepted after %0d gap cycles", "gap_hold", k);

`ifdef RF_TXN_TIMEOUT_EN
    // Withheld spi_done: abort exactly TMO cycles after spi_start.
    drop_unused();
    eng_withhold = 1'b1;
    issue_cmd(8'h9F, 2, 1'b1);
    k = 0;
    while (!spi_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo spi_start_seen", {31'd0, spi_start}, 32'd1);
    k = 0;
    while (!txn_done && k < TMO + 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo latency", k, TMO);
    check("tmo txn_err", {31'd0, txn_err}, 32'd1);
    check("tmo hold_csn", {31'd0, spi_hold_csn}, 32'd0);
    eng_withhold = 1'b0;
    wait_idle("tmo");
    $display("txn %-12s abort after %0d cycles", "timeout", k);
`endif

    // Asynchronous reset in the middle of a read.
    drop_unused();
    eng_lat_max = 3; eng_tail_max = 0;
    rx_stream.push_back(8'h5A);
    for (int i = 0; i < 32; i++) rx_stream.push_back(8'(8'hF0 ^ 8'(i)));
    b_rdv = n_rdv;
    issue_cmd(8'h61, 32, 1'b1);
    k = 0;
    while (n_rdv - b_rdv < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid progress", {31'd0, 1'(n_rdv - b_rdv >= 5)}, 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("rst_mid outputs", all_outs(), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1 check("rst_mid ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("rst_mid ready_after", {31'd0, cmd_ready}, 32'd1);
    $display("txn %-12s reset after %0d read bytes", "rst_mid", n_rdv - b_rdv);

    run_txn(tbl[1], 1'b1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_spi_txn_ctrl.md
RF_SPI_TXN_CTRL -- requirements
Module: rf_spi_txn_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, max data bytes per transaction; larger cmd_len is clamped to MAX_LEN.
REQ-002 SHALL have parameter GAP_CYC, default 20, clk cycles with CSN high between transactions.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, cycles from spi_start to spi_done before abort (REQ-027).
REQ-004 SHALL have port clk  in  1  clock; the block uses only its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  host transaction request.
REQ-007 SHALL have port cmd_ready  out  1  block accepts a command.
REQ-008 SHALL have port cmd_opcode  in  8  RF command byte, sent first.
REQ-009 SHALL have port cmd_len  in  6  data byte count after the opcode, 0..MAX_LEN.
REQ-010 SHALL have port cmd_rd  in  1  1 = read data bytes, 0 = write data bytes.
REQ-011 SHALL have ports wr_data  in  8, wr_valid  in  1  host write byte and its valid flag.
REQ-012 SHALL have port wr_pop  out  1  1-cycle pulse; the block consumed wr_data.
REQ-013 SHALL have ports rd_data  out  8, rd_valid  out  1  read byte, valid as a 1-cycle pulse.
REQ-014 SHALL have port status  out  8  RX byte received during the opcode byte.
REQ-015 SHALL have ports txn_done  out  1, txn_err  out  1  end-of-transaction pulse and abort flag.
REQ-016 SHALL have port busy  out  1  high from command acceptance to the end of the gap.
REQ-017 SHALL have ports spi_start  out  1, spi_tx_byte  out  8, spi_hold_csn  out  1  to the byte engine.
REQ-018 SHALL have ports spi_rx_byte  in  8, spi_done  in  1, spi_busy  in  1  from the byte engine.

Function
REQ-019 SHALL implement states IDLE -> OPC -> OPC_WAIT -> DAT -> DAT_WAIT -> GAP -> IDLE; OPC_WAIT goes to GAP directly when len = 0.
REQ-020 SHALL assert cmd_ready only in IDLE while spi_busy = 0; a cmd_valid & cmd_ready cycle latches opcode, clamped len and rd, then enters OPC.
REQ-021 SHALL in OPC/DAT drive spi_start for exactly 1 cycle, only when spi_busy = 0, and then move to the matching WAIT state.
REQ-022 SHALL hold spi_tx_byte registered and stable from the spi_start cycle until spi_done: opcode, wr_data for a write, or 8'hFF for a read.
REQ-023 SHALL for a write in DAT issue a byte only when wr_valid = 1; wr_pop pulses in the same cycle as spi_start; while wr_valid = 0 it waits in DAT with CSN held and no timeout counting.
REQ-024 SHALL on spi_done in OPC_WAIT register status <= spi_rx_byte; on each data-byte spi_done of a read, register rd_data and pulse rd_valid 1 cycle later.
REQ-025 SHALL drive spi_hold_csn = 1 (registered) from acceptance until the cycle after the final byte's spi_done, and 0 otherwise, so CSN stays low across inter-byte engine idle cycles.
REQ-026 SHALL pulse txn_done 1 cycle on entry to GAP; GAP lasts GAP_CYC cycles and also waits for spi_busy = 0; cmd_valid held during GAP is accepted on return to IDLE.
REQ-027 SHALL on abort per REQ-031 drop spi_hold_csn, pulse txn_done with txn_err = 1 in the same cycle, and enter GAP; otherwise txn_err = 0.
REQ-028 SHALL pulse at most one of spi_start, wr_pop, rd_valid, txn_done per byte event; no spi_start is issued in IDLE or GAP.

Reset
REQ-029 SHALL on rstn low, even mid-transaction, immediately force state IDLE, gap and timeout counters 0, and all outputs 0 (status 8'h00, spi_tx_byte 8'h00, spi_hold_csn 0).
REQ-030 SHALL raise cmd_ready no earlier than the first clk edge after rstn deasserts.

Configuration
REQ-031 SHALL with RF_TXN_TIMEOUT_EN defined count cycles in OPC_WAIT/DAT_WAIT and abort when the count reaches TIMEOUT_CYC without spi_done.
REQ-032 SHALL without RF_TXN_TIMEOUT_EN contain no timeout counter, tie txn_err to 0, and wait indefinitely for spi_done.

Verification
REQ-033 SHALL cover: opcode 8'hE1, len 0, engine returns 8'h0E -> 1 spi_start, status = 8'h0E, txn_done, hold_csn low after done.
REQ-034 SHALL cover: write 8'h20, len 1, wr_data 8'h0B -> tx bytes 20, 0B; 1 wr_pop; hold_csn high between bytes.
REQ-035 SHALL cover: read 8'h61, len 32, engine returns 0..31 -> 32 rd_valid pulses with rd_data 0..31 in order.
REQ-036 SHALL cover: write len 3 with wr_valid low for 50 cycles before byte 2 -> no spi_start during the stall, CSN held, bytes intact.
REQ-037 SHALL cover: with RF_TXN_TIMEOUT_EN, spi_done withheld -> txn_err with txn_done exactly TIMEOUT_CYC cycles after spi_start; rstn pulse mid-read -> all outputs 0.
